// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage feeding the 64-bit ALU.
// 32x64 register file, per-register scoreboard, one-entry output register.
module alu_issue_stage #(
  parameter int XLEN = 64,
  parameter int NREGS = 32,
  localparam int IW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [IW-1:0]   req_rs1,
  input  logic [IW-1:0]   req_rs2,
  input  logic [IW-1:0]   req_rd,
  input  logic [2:0]      req_op,
  input  logic            req_use_imm,
  input  logic [XLEN-1:0] req_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_control,
  output logic [IW-1:0]   out_rd,
  input  logic            wb_valid,
  input  logic [IW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [NREGS-1:0] busy_mask
);

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] wb_hot;
  logic [NREGS-1:0] rd_hot;
  logic [NREGS-1:0] sbe;
  logic             stall;
  logic             accept;
  logic [XLEN-1:0]  byp_a;
  logic [XLEN-1:0]  byp_b;
  logic [2:0]       ctl;

  // Reg 0 reads zero; a same-cycle writeback is forwarded.
  function automatic logic [XLEN-1:0] bypass(
    input logic [IW-1:0] r
  );
    if (r == '0) return '0;
    if (wb_valid && (wb_rd == r)) return wb_data;
    return rf[r];
  endfunction

  // One-hot masks for writeback and destination; reg 0 excluded.
  always_comb begin
    wb_hot = '0;
    rd_hot = '0;
    if (wb_valid && (wb_rd != '0)) wb_hot[wb_rd] = 1'b1;
    if (req_rd != '0) rd_hot[req_rd] = 1'b1;
  end

  // Hazard check against busy bits, with writeback unblocking.
  always_comb begin
    sbe = sb & ~wb_hot;
    stall = sbe[req_rs1]
          | (sbe[req_rs2] & ~req_use_imm)
          | sbe[req_rd];
    req_ready = ~rst & ~stall & (~out_valid | out_ready);
    accept = req_valid & req_ready;
  end

  // Operand selection and control sanitising.
  always_comb begin
    byp_a = bypass(req_rs1);
    byp_b = req_use_imm ? req_imm : bypass(req_rs2);
    unique case (req_op)
      3'b110, 3'b111: ctl = 3'b000;
      default:        ctl = req_op;
    endcase
  end

  // Register file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_valid && (wb_rd != '0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Scoreboard: writeback clears, issue sets (issue wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else begin
      sb <= (sb & ~wb_hot) | (accept ? rd_hot : '0);
    end
  end

  // One-entry output register with hold and drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_control <= 3'b000;
      out_rd      <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_a       <= byp_a;
      out_b       <= byp_b;
      out_control <= ctl;
      out_rd      <= req_rd;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  assign busy_mask = sb;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios then
// randomized traffic against a behavioural model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [4:0]  req_rd;
  logic [2:0]  req_op;
  logic        req_use_imm;
  logic [63:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [2:0]  out_control;
  logic [4:0]  out_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [31:0] busy_mask;

  int total = 0;
  int passed = 0;

  logic [63:0] m_rf [32];
  bit          m_sb [32];
  bit          m_ov;
  logic [63:0] m_a;
  logic [63:0] m_b;
  logic [2:0]  m_ctl;
  logic [4:0]  m_rd;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_op(req_op), .req_use_imm(req_use_imm),
    .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_control(out_control), .out_rd(out_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, got, exp);
  endtask

  function automatic bit m_busy(logic [4:0] r);
    if (r == 0) return 0;
    if (wb_valid && wb_rd == r) return 0;
    return m_sb[r];
  endfunction

  function automatic bit m_ready();
    if (rst) return 0;
    if (m_busy(req_rs1)) return 0;
    if (!req_use_imm && m_busy(req_rs2)) return 0;
    if (m_busy(req_rd)) return 0;
    return !m_ov || out_ready;
  endfunction

  function automatic logic [63:0] m_read(logic [4:0] r);
    if (r == 0) return 64'd0;
    if (wb_valid && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = m_sb[i];
    return m;
  endfunction

  // One clock: check ready before the edge, advance the
  // model at the edge, check registered outputs after it.
  task automatic cyc();
    bit acc;
    #1;
    chk("req_ready", req_ready, m_ready());
    acc = req_valid && m_ready();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_rf[i] = 0;
        m_sb[i] = 0;
      end
      m_ov = 0; m_a = 0; m_b = 0; m_ctl = 0; m_rd = 0;
    end else begin
      if (acc) begin
        m_ov  = 1;
        m_a   = m_read(req_rs1);
        m_b   = req_use_imm ? req_imm : m_read(req_rs2);
        m_ctl = (req_op > 5) ? 3'd0 : req_op;
        m_rd  = req_rd;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (wb_valid && wb_rd != 0) begin
        m_rf[wb_rd] = wb_data;
        m_sb[wb_rd] = 0;
      end
      if (acc && req_rd != 0) m_sb[req_rd] = 1;
    end
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_control", out_control, m_ctl);
    chk("out_rd", out_rd, m_rd);
    chk("busy_mask", busy_mask, m_mask());
  endtask

  task automatic idle();
    rst = 0; req_valid = 0;
    req_rs1 = 0; req_rs2 = 0; req_rd = 0;
    req_op = 0; req_use_imm = 0; req_imm = 0;
    out_ready = 1;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic req(logic [4:0] a, logic [4:0] b,
                     logic [4:0] d, logic [2:0] op);
    req_valid = 1; req_rs1 = a; req_rs2 = b;
    req_rd = d; req_op = op; req_use_imm = 0;
  endtask

  task automatic wb(logic [4:0] r, logic [63:0] v);
    wb_valid = 1; wb_rd = r; wb_data = v;
  endtask

  initial begin
    logic [63:0] sa;
    logic [63:0] sbv;
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    cyc();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_mask", busy_mask, 32'd0);

    // 1: basic issue
    idle(); wb(1, 5); cyc();
    idle(); wb(2, 7); cyc();
    idle(); req(1, 2, 3, 3'b000); cyc();
    chk("t1_a", out_a, 64'd5);
    chk("t1_b", out_b, 64'd7);
    chk("t1_ctl", out_control, 3'b000);
    chk("t1_rd", out_rd, 5'd3);
    chk("t1_busy3", busy_mask[3], 1'b1);

    // 2: RAW stall, released by same-cycle writeback
    idle(); req(3, 0, 5, 3'b001);
    #1;
    chk("t2_stall", req_ready, 1'b0);
    cyc();
    wb(3, 12); cyc();
    chk("t2_a", out_a, 64'd12);
    chk("t2_busy3", busy_mask[3], 1'b0);
    chk("t2_busy5", busy_mask[5], 1'b1);

    // 3: output hold under back-pressure
    idle(); out_ready = 0; req(1, 2, 6, 3'b010);
    sa = out_a; sbv = out_b;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_hold_a", out_a, sa);
      chk("t3_hold_b", out_b, sbv);
      chk("t3_hold_v", out_valid, 1'b1);
      chk("t3_ready", req_ready, 1'b0);
    end
    out_ready = 1; cyc();
    chk("t3_rd", out_rd, 5'd6);
    chk("t3_ctl", out_control, 3'b010);

    // 4: x0 source, immediate, illegal op maps to add
    idle(); req(0, 9, 7, 3'b111);
    req_use_imm = 1; req_imm = '1;
    wb(0, 9); cyc();
    chk("t4_a", out_a, 64'd0);
    chk("t4_b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_ctl", out_control, 3'b000);
    idle(); req(0, 0, 0, 3'b100); cyc();
    chk("t4_x0a", out_a, 64'd0);
    chk("t4_x0b", out_b, 64'd0);
    chk("t4_busy0", busy_mask[0], 1'b0);

    // 5: issue wins over same-edge writeback to rd
    idle(); req(1, 2, 4, 3'b011); wb(4, 33); cyc();
    chk("t5_busy4", busy_mask[4], 1'b1);
    idle(); req(1, 2, 4, 3'b101);
    #1;
    chk("t5_stall", req_ready, 1'b0);
    cyc(); cyc();
    wb(4, 44); cyc();
    chk("t5_rd", out_rd, 5'd4);
    chk("t5_ctl", out_control, 3'b101);
    chk("t5_busy4b", busy_mask[4], 1'b1);

    // 6: reset with a held entry and busy bits
    idle(); out_ready = 0; cyc();
    rst = 1; cyc();
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_mask", busy_mask, 32'd0);
    idle(); req(1, 2, 8, 3'b000); cyc();
    chk("t6_a", out_a, 64'd0);
    chk("t6_b", out_b, 64'd0);

    // Randomized traffic with hazards concentrated on x0..x7
    for (int n = 0; n < 800; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      req_valid   = ($urandom_range(0, 3) != 0);
      req_rs1     = 5'($urandom_range(0, 7));
      req_rs2     = 5'($urandom_range(0, 7));
      req_rd      = 5'($urandom_range(0, 7));
      req_op      = 3'($urandom_range(0, 7));
      req_use_imm = 1'($urandom_range(0, 1));
      req_imm     = {$urandom, $urandom};
      out_ready   = ($urandom_range(0, 3) != 0);
      wb_valid    = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = {$urandom, $urandom};
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
